// File: rtl/cache_req_ctrl.sv
// cache_req_ctrl: request sequencer placed in front of a K-way CLOCK cache.
//
// Client requests arrive on a valid/ready handshake and are handled one at a time.
// A read first looks the address up in the cache. A hit answers straight from the cache.
// A miss fetches the line from backing memory, writes it into the cache, and then answers.
// A write is write-through: the cache is filled first and memory is written after that.
// A cache fill that the cache never acknowledges is abandoned after FILL_TIMEOUT cycles.
// In that case the response carries resp_err.
//
// Ports
//   clock, reset_n                     clock (rising edge), async active-low reset
//   req_valid/req_ready                client request handshake
//   req_write, req_addr, req_wdata     request kind, address, write data
//   resp_valid/resp_ready              response handshake; response held until taken
//   resp_data, resp_hit, resp_err      read data (0 for writes), cache hit, fill timeout
//   cache_read, cache_write            cache strobes (mutually exclusive)
//   cache_addr, cache_wval             cache address and fill value
//   cache_hit, cache_rval              registered cache results
//   mem_req_valid/mem_req_ready        memory request handshake
//   mem_we, mem_addr, mem_wdata        memory request contents
//   mem_resp_valid, mem_resp_data      single-cycle memory read return

module cache_req_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned LINE_WIDTH   = 32,
    parameter int unsigned K            = 2,
    parameter int unsigned FILL_TIMEOUT = 2 * K + 4
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LINE_WIDTH-1:0] req_wdata,

    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [LINE_WIDTH-1:0] resp_data,
    output logic                  resp_hit,
    output logic                  resp_err,

    output logic                  cache_read,
    output logic                  cache_write,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [LINE_WIDTH-1:0] cache_wval,
    input  logic                  cache_hit,
    input  logic [LINE_WIDTH-1:0] cache_rval,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic                  mem_resp_valid,
    input  logic [LINE_WIDTH-1:0] mem_resp_data
);

    localparam int unsigned CNT_W = $clog2(FILL_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    // The value the counter holds during the last fill cycle that is allowed.
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StCheck,
        StMemReq,
        StMemWait,
        StFill,
        StResp
    } state_e;

    state_e                state_q;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    // Counts completed FILL cycles. A value of 0 means this is the first fill cycle.
    logic [CNT_W-1:0]      fill_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            write_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            fill_cnt_q    <= '0;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            resp_hit      <= 1'b0;
            resp_err      <= 1'b0;
            cache_read    <= 1'b0;
            cache_write   <= 1'b0;
            cache_addr    <= '0;
            cache_wval    <= '0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        write_q    <= req_write;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        req_ready  <= 1'b0;
                        cache_addr <= req_addr;
                        if (req_write) begin
                            cache_write <= 1'b1;
                            cache_wval  <= req_wdata;
                            fill_cnt_q  <= '0;
                            state_q     <= StFill;
                        end else begin
                            cache_read <= 1'b1;
                            state_q    <= StLookup;
                        end
                    end
                end

                StLookup: begin
                    cache_read <= 1'b0;
                    state_q    <= StCheck;
                end

                StCheck: begin
                    if (cache_hit) begin
                        resp_valid <= 1'b1;
                        resp_data  <= cache_rval;
                        resp_hit   <= 1'b1;
                        resp_err   <= 1'b0;
                        state_q    <= StResp;
                    end else begin
                        mem_req_valid <= 1'b1;
                        mem_we        <= 1'b0;
                        mem_addr      <= addr_q;
                        mem_wdata     <= wdata_q;
                        state_q       <= StMemReq;
                    end
                end

                StMemReq: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_we        <= 1'b0;
                        mem_addr      <= '0;
                        mem_wdata     <= '0;
                        if (write_q) begin
                            resp_valid <= 1'b1;
                            resp_data  <= '0;
                            resp_hit   <= 1'b0;
                            resp_err   <= 1'b0;
                            state_q    <= StResp;
                        end else begin
                            state_q <= StMemWait;
                        end
                    end
                end

                StMemWait: begin
                    if (mem_resp_valid) begin
                        resp_data   <= mem_resp_data;
                        cache_write <= 1'b1;
                        cache_addr  <= addr_q;
                        cache_wval  <= mem_resp_data;
                        fill_cnt_q  <= '0;
                        state_q     <= StFill;
                    end
                end

                StFill: begin
                    // During the first fill cycle, cache_hit still refers to an earlier access.
                    if ((fill_cnt_q != '0) && cache_hit) begin
                        cache_write <= 1'b0;
                        cache_wval  <= '0;
                        if (write_q) begin
                            mem_req_valid <= 1'b1;
                            mem_we        <= 1'b1;
                            mem_addr      <= addr_q;
                            mem_wdata     <= wdata_q;
                            state_q       <= StMemReq;
                        end else begin
                            resp_valid <= 1'b1;
                            resp_hit   <= 1'b0;
                            resp_err   <= 1'b0;
                            state_q    <= StResp;
                        end
                    end else if (fill_cnt_q >= FILL_LAST) begin
                        // The fill is abandoned. A write does not go on to update memory.
                        cache_write <= 1'b0;
                        cache_wval  <= '0;
                        resp_valid  <= 1'b1;
                        resp_hit    <= 1'b0;
                        resp_err    <= 1'b1;
                        if (write_q) begin
                            resp_data <= '0;
                        end
                        state_q <= StResp;
                    end else if (fill_cnt_q != CNT_MAX) begin
                        fill_cnt_q <= fill_cnt_q + 1'b1;
                    end
                end

                StResp: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_data  <= '0;
                        resp_hit   <= 1'b0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state_q    <= StIdle;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
